lenet5_frame_loader: RTL



---
 rtl/lenet5_frame_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lenet5_frame_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lenet5_frame_loader: pixel stream -> flat row-major frame for LeNet-5 core  |
// | Optional macro LOADER_PAD_EN: zero-border padding. Revision: 1.0            |
// +----------------------------------------------------------------------------+
module lenet5_frame_loader #(
    parameter int IN_H  = 32,
    parameter int IN_W  = 32,
    parameter int WIDTH = 16,
    parameter int PAD   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [WIDTH-1:0]       pix_data,
    input  logic                          pix_valid,
    input  logic                          pix_last,
    output logic                          pix_ready,
    output logic [IN_H*IN_W*WIDTH-1:0]    frame_vec,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic                          len_err,
    output logic [15:0]                   frame_cnt
);

`ifdef LOADER_PAD_EN
    localparam int SH = IN_H - 2*PAD;
    localparam int SW = IN_W - 2*PAD;
    generate
        if (2*PAD >= IN_H || 2*PAD >= IN_W) begin : g_pad_check
            $error("lenet5_frame_loader: 2*PAD must be smaller than IN_H and IN_W");
        end
    endgenerate
`else
    localparam int SH = IN_H;
    localparam int SW = IN_W;
    generate
        if (PAD < 0) begin : g_pad_check
            $error("lenet5_frame_loader: PAD must be non-negative");
        end
    endgenerate
`endif

    localparam int NPIX = IN_H * IN_W;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int RW   = (SH > 1) ? $clog2(SH) : 1;
    localparam int CW   = (SW > 1) ? $clog2(SW) : 1;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              len_err_q, len_err_d;
    logic [WIDTH-1:0]  frame_q [NPIX];
    logic              accept;
    logic              last_pos;
    logic [AW-1:0]     addr;

    assign accept   = pix_valid && pix_ready;
    assign last_pos = (row_q == RW'(SH-1)) && (col_q == CW'(SW-1));

`ifdef LOADER_PAD_EN
    assign addr = (AW'(row_q) + AW'(PAD)) * AW'(IN_W) + AW'(col_q) + AW'(PAD);
`else
    assign addr = AW'(row_q) * AW'(IN_W) + AW'(col_q);
`endif

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (last_pos) begin
                        state_d   = S_HOLD;
                        row_d     = '0;
                        col_d     = '0;
                        cnt_d     = cnt_q + 16'd1;
                        len_err_d = !pix_last;
                    end else if (pix_last) begin
                        // Early last: discard the partial frame, restart at address 0.
                        row_d     = '0;
                        col_d     = '0;
                        len_err_d = 1'b1;
                    end else if (col_q == CW'(SW-1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (frame_ready) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FILL;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                frame_q[i] <= '0;
            end
        end else if (accept) begin
            frame_q[addr] <= pix_data;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NPIX; p++) begin : g_pack
            assign frame_vec[p*WIDTH +: WIDTH] = frame_q[p];
        end
    endgenerate

    // Handshakes decode the state register only; rst_n keeps pix_ready low in reset.
    assign pix_ready   = rst_n && (state_q == S_FILL);
    assign frame_valid = (state_q == S_HOLD);
    assign len_err     = len_err_q;
    assign frame_cnt   = cnt_q;

endmodule
`default_nettype wire
